// File: rtl/if_id_fetch_queue.sv
// IF/ID instruction fetch queue: DEPTH-entry circular buffer of {pc, instr}
// with valid/ready on both sides, one-cycle flush and a nop bubble when empty.
module if_id_fetch_queue #(
  parameter int unsigned   DEPTH     = 4,
  parameter int unsigned   PTR_W     = 2,
  parameter logic [31:0]   BUBBLE_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  input  logic             out_ready,
  input  logic             flush,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push, pop;
  logic [63:0]      head;

  assign in_ready  = (cnt_q != CNT_FULL);
  assign out_valid = (cnt_q != '0);
  assign count     = cnt_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // No bypass: the head always comes from storage, so a push is visible next cycle.
  assign head      = mem_q[rd_ptr_q];
  assign out_pc    = out_valid ? head[63:32] : BUBBLE_PC;
  assign out_instr = out_valid ? head[31:0]  : '0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry contents are never read while invalid, so storage is left unreset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_pc, in_instr};
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed self-checking bench for if_id_fetch_queue (DEPTH=4).
module tb_if_id_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  if_id_fetch_queue #(
    .DEPTH    (4),
    .PTR_W    (2),
    .BUBBLE_PC(32'h0000_3000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .out_ready(out_ready),
    .flush    (flush),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'h2400, pc[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    out_ready = 1'b0; flush = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int unsigned n);
    out_ready = 1'b0;
    for (int unsigned k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_pc    = base + 32'(4 * k);
      in_instr = instr_of(in_pc);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic scen1();
    in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'h3C01_1234; out_ready = 1'b0;
    check("s1_pre_valid", 64'(out_valid), 64'(0));
    check("s1_pre_instr", 64'(out_instr), 64'(0));
    check("s1_pre_pc",    64'(out_pc),    64'(32'h3000));
    step();
    in_valid = 1'b0;
    check("s1_valid", 64'(out_valid), 64'(1));
    check("s1_pc",    64'(out_pc),    64'(32'h3000));
    check("s1_instr", 64'(out_instr), 64'(32'h3C01_1234));
    check("s1_count", 64'(count),     64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_ready", 64'(in_ready),  64'(1));
    check("rst_count", 64'(count),     64'(0));
    check("rst_pc",    64'(out_pc),    64'(32'h3000));
    check("rst_instr", 64'(out_instr), 64'(0));

    scen1();

    // Fill, reject fifth, drain in order.
    do_reset();
    push_seq(32'h3000, 4);
    check("s2_count_full", 64'(count),    64'(4));
    check("s2_ready_full", 64'(in_ready), 64'(0));
    in_valid = 1'b1; in_pc = 32'h3010; in_instr = instr_of(32'h3010);
    step();
    in_valid = 1'b0;
    check("s2_reject_count", 64'(count),  64'(4));
    check("s2_reject_head",  64'(out_pc), 64'(32'h3000));
    out_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      check("s2_drain_pc",    64'(out_pc),    64'(32'h3000 + 32'(4 * k)));
      check("s2_drain_instr", 64'(out_instr), 64'(instr_of(32'h3000 + 32'(4 * k))));
      step();
    end
    out_ready = 1'b0;
    check("s2_empty_valid", 64'(out_valid), 64'(0));
    check("s2_empty_pc",    64'(out_pc),    64'(32'h3000));
    check("s2_empty_instr", 64'(out_instr), 64'(0));

    // Streaming across two pointer wraps.
    do_reset();
    out_ready = 1'b1;
    for (int unsigned k = 0; k <= 10; k++) begin
      in_valid = (k < 10);
      in_pc    = 32'h3000 + 32'(4 * k);
      in_instr = instr_of(in_pc);
      if (k > 0) begin
        check("s3_pc",    64'(out_pc),    64'(32'h3000 + 32'(4 * (k - 1))));
        check("s3_count", 64'(count),     64'(1));
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("s3_end_count", 64'(count), 64'(0));

    // Flush beats same-cycle push and pop.
    do_reset();
    push_seq(32'h5000, 3);
    check("s4_count3", 64'(count), 64'(3));
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h4000; in_instr = instr_of(32'h4000);
    out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("s4_count", 64'(count),     64'(0));
    check("s4_valid", 64'(out_valid), 64'(0));
    push_seq(32'h4004, 1);
    check("s4_head",  64'(out_pc), 64'(32'h4004));
    check("s4_count1", 64'(count), 64'(1));

    // Asynchronous reset mid-cycle.
    do_reset();
    push_seq(32'h7000, 2);
    check("s5_count2", 64'(count), 64'(2));
    #2 reset = 1'b0;
    #1;
    check("s5_valid", 64'(out_valid), 64'(0));
    check("s5_pc",    64'(out_pc),    64'(32'h3000));
    check("s5_instr", 64'(out_instr), 64'(0));
    check("s5_count", 64'(count),     64'(0));
    check("s5_ready", 64'(in_ready),  64'(1));
    step();
    reset = 1'b1;
    check("s5_hold_count", 64'(count), 64'(0));
    scen1();

    // Full with held push: one pop frees one slot.
    do_reset();
    push_seq(32'h6000, 4);
    in_valid = 1'b1; in_pc = 32'h6010; in_instr = instr_of(32'h6010);
    out_ready = 1'b1;
    check("s6_ready0", 64'(in_ready), 64'(0));
    step();
    out_ready = 1'b0;
    check("s6_count3", 64'(count),    64'(3));
    check("s6_ready1", 64'(in_ready), 64'(1));
    check("s6_head",   64'(out_pc),   64'(32'h6004));
    step();
    in_valid = 1'b0;
    check("s6_count4", 64'(count),    64'(4));
    check("s6_ready2", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      check("s6_drain_pc", 64'(out_pc), 64'(32'h6004 + 32'(4 * k)));
      step();
    end
    out_ready = 1'b0;
    check("s6_empty", 64'(out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
- Instruction fetch queue between the instruction fetch unit and the decode stage of the MIPS pipeline.
- Buffers up to DEPTH {PC, instruction} pairs using a valid/ready handshake on both sides, so a decode stall does not stall fetch until the queue is full.
- A flush input (branch/jump redirect) discards all buffered entries in one cycle.
- When empty it presents a bubble: instruction 32'h00000000 (sll $0,$0,0 = nop).

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH); pointer width.
- BUBBLE_PC, 32'h00003000, out_pc value driven while the queue is empty.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately
- in_valid  input  1  fetch unit presents a valid pair this cycle
- in_pc  input  32  PC of the fetched instruction
- in_instr  input  32  fetched instruction word
- in_ready  output  1  queue accepts a push this cycle
- out_valid  output  1  head entry valid for decode
- out_pc  output  32  PC of the head entry
- out_instr  output  32  instruction of the head entry
- out_ready  input  1  decode consumes the head entry this cycle
- flush  input  1  discard all entries and the same-cycle push
- count  output  PTR_W+1  number of valid entries, 0..DEPTH

Behaviour:
- Storage: DEPTH-entry circular buffer of 64-bit {pc, instr}; read pointer rd_ptr, write pointer wr_ptr, occupancy counter cnt (PTR_W+1 bits).
- Reset (reset==0, asynchronous): rd_ptr=0, wr_ptr=0, cnt=0. Outputs go immediately to out_valid=0, out_pc=BUBBLE_PC, out_instr=0, in_ready=1, count=0. Storage contents are don't-care.
- in_ready = (cnt != DEPTH). It is combinational from state only and never depends on out_ready (no pass-through when full).
- push = in_valid & in_ready & ~flush. pop = out_valid & out_ready & ~flush.
- out_valid = (cnt != 0).
- out_pc / out_instr = entry[rd_ptr] when out_valid, else BUBBLE_PC / 32'h0.
- Latency: a pushed entry becomes visible at the output on the cycle after the push edge at the earliest. There is no same-cycle bypass, even when empty.
- On each rising edge with reset==1:
  - flush=1: rd_ptr<=0, wr_ptr<=0, cnt<=0. Same-cycle push and pop are ignored. flush has priority over everything.
  - push only: write entry[wr_ptr], wr_ptr<=wr_ptr+1 (wraps modulo DEPTH), cnt<=cnt+1.
  - pop only: rd_ptr<=rd_ptr+1 (wraps), cnt<=cnt-1.
  - push and pop together (cnt is neither 0 nor DEPTH): both pointers advance, cnt unchanged.
  - Push while full is impossible by construction (in_ready=0). in_valid is ignored and the fetch side must hold its data.
  - Pop while empty is impossible (out_valid=0). out_ready is ignored.
- Pointer wrap: entry DEPTH-1 is followed by entry 0. Order is strictly FIFO across the wrap.
- Stability: while out_valid=1 and out_ready=0, out_pc/out_instr hold stable until a pop or flush.
- count = cnt, registered.
- Reset mid-operation: all entries are lost at once. After release, the first push edge is the first state change.
- in_pc/in_instr are not checked; the word 0 is queued like any other instruction, with out_valid=1.

Test Plan:
1. Reset, then push PC 0x3000/instr 0x3C011234 with out_ready=0 → next cycle out_valid=1, out_pc=0x3000, out_instr=0x3C011234, count=1. Same cycle as the push: out_valid=0, out_instr=0.
2. Push PCs 0x3000,0x3004,0x3008,0x300C with out_ready=0 → count=4, in_ready=0. Fifth in_valid (0x3010) is not accepted. Then out_ready=1 for 4 cycles → outputs 0x3000..0x300C in order, then out_valid=0, out_pc=0x00003000, out_instr=0.
3. Steady stream: push 0x3000+4k every cycle with out_ready=1 → count stays 1 after first cycle. 10 consecutive PCs emerge in order across two pointer wraps.
4. count=3, assert flush together with in_valid (PC 0x4000) and out_ready → next cycle count=0, out_valid=0. 0x4000 is not delivered. A subsequent push of 0x4004 emerges first.
5. Assert reset=0 asynchronously mid-cycle with count=2 → outputs go to the bubble values and count=0 before the next clock edge. After release, the queue behaves as in scenario 1.
6. Full queue with in_valid=1 held and out_ready pulsed for one cycle → exactly one pop. in_ready rises the cycle after the pop, the held entry is accepted on the following edge, and count returns to 4.
